// File: rtl/pim_out_pkg.sv
// pim_out_pkg: shared types, sizes and byte-extension helper for the PIM output drain path.
package pim_out_pkg;
    localparam int N_LANES = 4;
    localparam int N_BUF   = 2;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {PACK = 2'd0, ZEXT = 2'd1, SEXT = 2'd2} mode_e;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_e;

    function automatic logic [31:0] ext_byte(input logic [BYTE_W-1:0] b, input logic sext);
        return {{(32-BYTE_W){sext & b[BYTE_W-1]}}, b};
    endfunction
endpackage

// File: rtl/buffer_8b_reader.sv
// buffer_8b_reader: snapshots both output buffers and streams them as packed words or extended bytes.
module buffer_8b_reader
    import pim_out_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              clear_i,
    output logic              buf_read_en_o,
    input  logic [BYTE_W-1:0] output_1_i [0:N_LANES-1],
    input  logic [BYTE_W-1:0] output_2_i [0:N_LANES-1],
    output logic [31:0]       data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o
);
    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [2:0]        idx_q, idx_d;
    logic              done_q, done_d, accept, last;
    logic [BYTE_W-1:0] snap_q [0:N_BUF*N_LANES-1];
    logic [31:0]       elem;

    assign accept = state_q == IDLE && start_i && !clear_i;
    assign last   = mode_q == PACK ? idx_q == 3'd1 : idx_q == 3'd7;
    // Packed mode uses idx[0] to pick the buffer; extended modes index the flat snapshot.
    assign elem   = mode_q == PACK
                  ? (idx_q[0] ? {snap_q[4], snap_q[5], snap_q[6], snap_q[7]}
                              : {snap_q[0], snap_q[1], snap_q[2], snap_q[3]})
                  : ext_byte(snap_q[idx_q], mode_q == SEXT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
                LOAD: state_d = SEND;
                SEND: if (ready_i) begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= PACK;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int l = 0; l < N_BUF*N_LANES; l++) snap_q[l] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (accept) mode_q <= mode_i == 2'd3 ? PACK : mode_e'(mode_i);
            // The buffer only drives real data while its read enable is high, i.e. during LOAD.
            if (state_q == LOAD) begin
                for (int l = 0; l < N_LANES; l++) begin
                    snap_q[l]         <= output_1_i[l];
                    snap_q[l+N_LANES] <= output_2_i[l];
                end
            end
        end
    end

    assign buf_read_en_o = state_q == LOAD;
    assign valid_o       = state_q == SEND;
    assign busy_o        = state_q != IDLE;
    assign data_o        = valid_o ? elem : '0;
    assign done_o        = done_q;
endmodule
